ud_counter_sched: RTL and testbench
===================================

// Module: ud_counter_sched
// PURPOSE
//  Scheduler that shares one mod-12 up/down counter (up_DW_counter) between NUM_REQ requesters.
//  Round-robin arbitration; each granted command (CLEAR/LOAD/UP n/DOWN n) runs to completion.
//  The counter has no enable: while idle, this block holds the count by reloading it (load=1, din=count).
//  Sits between requester logic and the counter; drives the counter's din/load/mode/reset pins.
// PARAMETERS
//  NUM_REQ  2   number of requesters (2..4)
//  STEP_W   4   width of step count for UP/DOWN
//  MOD_MAX  11  highest count value; used only by the bench model and for documentation
// PORTS
//  clock      in   1            single clock; all logic on posedge
//  reset      in   1            asynchronous, active-high
//  req_valid  in   NUM_REQ      per-requester command valid
//  req_ready  out  NUM_REQ      per-requester accept; one-hot or zero
//  req_op     in   2*NUM_REQ    op per requester, slice [2i+1:2i]: 00 CLEAR, 01 LOAD, 10 UP, 11 DOWN
//  req_data   in   4*NUM_REQ    LOAD value, slice [4i+3:4i]
//  req_steps  in   STEP_W*NUM_REQ  UP/DOWN step count, slice i
//  rsp_valid  out  1            one-cycle completion pulse; no backpressure
//  rsp_id     out  2            index of the requester that completed
//  rsp_count  out  4            counter value after the operation
//  ctr_count  in   4            counter output (count)
//  ctr_din    out  4            to counter din
//  ctr_load   out  1            to counter load
//  ctr_mode   out  1            to counter mode (1 = up)
//  ctr_clr    out  1            to counter reset (synchronous clear in the counter)
// BEHAVIOUR
//  FSM states: INIT, IDLE, EXEC, RESP. Counter-side outputs are decoded from state.
//  Reset (async): state=INIT, rr pointer=0, rsp_valid=0, rsp_id=0, rsp_count=0, req_ready=0.
//  INIT: ctr_clr=1 for one cycle, then IDLE. Counter reads 0 from the following edge.
//  IDLE: ctr_load=1, ctr_din=ctr_count (hold). Grant goes to the first valid requester at or after the pointer.
//   The grant sets req_ready[g]=1 combinationally. On valid&ready, capture op/data/steps/id.
//   The pointer moves to g+1 (mod NUM_REQ); next state is EXEC. With no valid requester, IDLE holds.
//  EXEC CLEAR: ctr_clr=1 for one cycle -> RESP.
//  EXEC LOAD: ctr_load=1, ctr_din=data for one cycle -> RESP. A value >MOD_MAX passes unchanged.
//   A following UP from such a value wraps to 0 (counter rule: count>=11 -> 0).
//  EXEC UP/DOWN: ctr_load=0, ctr_clr=0, ctr_mode=(op==UP) for exactly steps cycles.
//   Remaining-step counter decrements each cycle; leave EXEC when it reaches 1.
//   steps=0: one hold cycle (load=1, din=count) -> RESP; count unchanged.
//  Wrap: up 11->0, down 0->11; no flag raised.
//  RESP: hold counter; rsp_valid=1 for one cycle, rsp_id=captured id, rsp_count=ctr_count -> IDLE.
//  Timing: accept at cycle T; EXEC T+1..T+k (k = 1 for CLEAR/LOAD, max(steps,1) for UP/DOWN).
//   rsp_valid at T+k+1; next accept no earlier than T+k+2.
//  No accept outside IDLE. req_ready=0 in INIT, EXEC and RESP; requester inputs are ignored there.
//  Simultaneous valids: only one grant per accept, by round-robin.
//  A requester that drops valid before ready loses nothing; the pointer is unchanged.
//  Reset mid-EXEC/RESP: operation aborted, no rsp_valid, re-enter INIT.
//   Counter is cleared one cycle after reset deasserts.
// STRUCTURE
//  Package ud_ctr_pkg: op_t enum (OP_CLEAR, OP_LOAD, OP_UP, OP_DOWN), state_t enum, CTR_W=4, CTR_MAX=11.
//  Sub-module rr_arbiter #(N): inputs req, ptr; output one-hot grant. Purely combinational.
//  Top level: FSM, capture registers, step counter, rsp registers, counter-pin decode.
// TESTING (bench instantiates ud_counter_sched + up_DW_counter + mod-12 reference model)
//  1 Reset 3 cycles then release -> one ctr_clr cycle, count=0, no rsp_valid, req_ready=0 during INIT.
//  2 From 0, req0 UP steps=13 accepted at T -> rsp_valid at T+14, rsp_id=0, rsp_count=1 (wrap 11->0 exercised).
//  3 req1 LOAD 7, then req1 DOWN steps=9 -> first rsp_count=7; second rsp_count=10 (wrap 0->11).
//  4 req0 and req1 both valid continuously with UP steps=1 -> grants alternate 0,1,0,1; count +1 per rsp.
//  5 reset asserted during a DOWN steps=10 -> no rsp_valid, req_ready=0; count=0 after INIT.
//  6 No requests for 20 cycles after LOAD 5 -> count stays 5 every cycle. Also steps=0 -> rsp_count=5.

Source files
------------

// File: rtl/ud_counter_sched_pkg.sv
// ud_ctr_pkg: types and constants shared by the counter scheduler and its bench.
//   op_t    : command encoding on req_op (00 CLEAR, 01 LOAD, 10 UP, 11 DOWN)
//   state_t : scheduler FSM states
//   CTR_W   : counter width, CTR_MAX : highest count before wrap
package ud_ctr_pkg;

  localparam int CTR_W   = 4;
  localparam int CTR_MAX = 11;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_UP    = 2'b10,
    OP_DOWN  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

endpackage

// File: rtl/ud_counter_sched_if.sv
// ud_counter_sched_if: requester command bus and completion response bus.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_op/data/steps   : packed per-requester command fields
//   rsp_valid/id/count  : one-cycle completion pulse, no backpressure
// master = requester side, slave = scheduler side.
interface ud_counter_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int STEP_W  = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [2*NUM_REQ-1:0]      req_op;
  logic [4*NUM_REQ-1:0]      req_data;
  logic [STEP_W*NUM_REQ-1:0] req_steps;
  logic                      rsp_valid;
  logic [1:0]                rsp_id;
  logic [3:0]                rsp_count;

  modport master (
    output req_valid, req_op, req_data, req_steps,
    input  req_ready, rsp_valid, rsp_id, rsp_count
  );

  modport slave (
    input  req_valid, req_op, req_data, req_steps,
    output req_ready, rsp_valid, rsp_id, rsp_count
  );
endinterface

// File: rtl/ud_counter_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req   : request vector
//   ptr   : highest-priority index this round
//   grant : one-hot grant of the first request at or after ptr (zero if none)
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [N-1:0] grant
);
  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/up_DW_counter.sv
// up_DW_counter: mod-12 up/down counter with no enable.
//   clock : posedge clock
//   reset : synchronous clear (highest priority)
//   load  : count <= din
//   mode  : 1 = count up (>=11 wraps to 0), 0 = count down (0 wraps to 11)
//   din   : load value, count : current value
module up_DW_counter
  import ud_ctr_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             mode,
  input  logic [CTR_W-1:0] din,
  output logic [CTR_W-1:0] count
);
  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= din;
    else if (mode)
      count <= (count >= CTR_W'(CTR_MAX)) ? '0 : count + 1'b1;
    else
      count <= (count == '0) ? CTR_W'(CTR_MAX) : count - 1'b1;
  end
endmodule

// File: rtl/ud_counter_sched.sv
// ud_counter_sched: shares one mod-12 up/down counter between NUM_REQ requesters.
//   clock, reset : posedge clock, asynchronous active-high reset
//   bus          : requester commands in, completion responses out (slave side)
//   ctr_count    : counter value in
//   ctr_din/ctr_load/ctr_mode/ctr_clr : counter control pins
// Commands are granted round-robin and run to completion. The counter has no
// enable, so whenever nothing is executing it is held by reloading its own value.
module ud_counter_sched
  import ud_ctr_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int STEP_W  = 4,
  parameter int MOD_MAX = 11
) (
  input  logic             clock,
  input  logic             reset,
  ud_counter_sched_if.slave bus,
  input  logic [CTR_W-1:0] ctr_count,
  output logic [CTR_W-1:0] ctr_din,
  output logic             ctr_load,
  output logic             ctr_mode,
  output logic             ctr_clr
);
  if (MOD_MAX != CTR_MAX) begin : g_mod_check
    $error("MOD_MAX must match the counter wrap value CTR_MAX");
  end

  state_t             state, state_nxt;
  logic [1:0]         ptr;
  logic [1:0]         id_q;
  op_t                op_q;
  logic [CTR_W-1:0]   data_q;
  logic [STEP_W-1:0]  rem_q;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         gnt_idx;
  logic               accept;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) gnt_idx = 2'(i);
  end

  assign accept        = (state == ST_IDLE) && (|grant);
  assign bus.req_ready = (state == ST_IDLE) ? grant : '0;

  // Control state: FSM, round-robin pointer, captured id/op and step counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      ptr   <= '0;
      id_q  <= '0;
      op_q  <= OP_CLEAR;
      rem_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        id_q  <= gnt_idx;
        op_q  <= op_t'(bus.req_op[2*gnt_idx +: 2]);
        rem_q <= bus.req_steps[STEP_W*gnt_idx +: STEP_W];
        ptr   <= (int'(gnt_idx) == NUM_REQ-1) ? 2'd0 : gnt_idx + 2'd1;
      end else if (state == ST_EXEC && rem_q > STEP_W'(1)) begin
        rem_q <= rem_q - 1'b1;
      end
    end
  end

  // LOAD payload; only meaningful after an accept, so it carries no reset
  always_ff @(posedge clock) begin
    if (accept)
      data_q <= bus.req_data[4*gnt_idx +: 4];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: state_nxt = ST_IDLE;
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (op_q == OP_CLEAR || op_q == OP_LOAD || rem_q <= STEP_W'(1))
          state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Counter pin decode; default is "hold" by reloading the current count
  always_comb begin
    ctr_din  = ctr_count;
    ctr_load = 1'b0;
    ctr_mode = 1'b1;
    ctr_clr  = 1'b0;
    case (state)
      ST_INIT: ctr_clr = 1'b1;
      ST_IDLE, ST_RESP: ctr_load = 1'b1;
      ST_EXEC: begin
        case (op_q)
          OP_CLEAR: ctr_clr = 1'b1;
          OP_LOAD: begin
            ctr_load = 1'b1;
            ctr_din  = data_q;
          end
          default: begin
            // steps=0 still spends one EXEC cycle, holding the count
            if (rem_q == '0)
              ctr_load = 1'b1;
            else
              ctr_mode = (op_q == OP_UP);
          end
        endcase
      end
      default: ctr_clr = 1'b1;
    endcase
  end

  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_id    = (state == ST_RESP) ? id_q : 2'd0;
  assign bus.rsp_count = (state == ST_RESP) ? ctr_count : 4'd0;

endmodule

// File: tb/tb_ud_counter_sched.sv
// Bench for ud_counter_sched driving a real up_DW_counter. Command vectors carry
// their expected completion count; accepted commands push {id, count, cycle} to
// a scoreboard that a response monitor pops on every rsp_valid.
module tb_ud_counter_sched;
  import ud_ctr_pkg::*;

  typedef struct {
    int  id;
    op_t op;
    int  data;
    int  steps;
    int  exp;
  } vec_t;

  typedef struct {
    int id;
    int count;
    int cyc;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [CTR_W-1:0] ctr_count, ctr_din;
  logic             ctr_load, ctr_mode, ctr_clr;
  int               cyc = 0;
  int               n_vec = 0;
  int               n_bad = 0;
  exp_t             sbq[$];
  exp_t             e;
  vec_t             vt[9];

  ud_counter_sched_if #(.NUM_REQ(2), .STEP_W(4)) bus ();

  ud_counter_sched #(.NUM_REQ(2), .STEP_W(4), .MOD_MAX(11)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .ctr_count (ctr_count),
    .ctr_din   (ctr_din),
    .ctr_load  (ctr_load),
    .ctr_mode  (ctr_mode),
    .ctr_clr   (ctr_clr)
  );

  up_DW_counter u_ctr (
    .clock (clock),
    .reset (ctr_clr),
    .load  (ctr_load),
    .mode  (ctr_mode),
    .din   (ctr_din),
    .count (ctr_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every completion must match the oldest outstanding command
  always @(negedge clock) begin
    if (bus.rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_rsp: got id %0d count %0d, expected no response (cycle %0d)",
                 bus.rsp_id, bus.rsp_count, cyc);
      end else begin
        e = sbq.pop_front();
        check("rsp_id", int'(bus.rsp_id), e.id);
        check("rsp_count", int'(bus.rsp_count), e.count);
        check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input int id, input op_t op, input int data, input int steps,
                       input int exp);
    int k;
    bit got;
    k = (op == OP_UP || op == OP_DOWN) ? ((steps < 1) ? 1 : steps) : 1;
    @(negedge clock);
    bus.req_op[2*id +: 2]    = op;
    bus.req_data[4*id +: 4]  = 4'(data);
    bus.req_steps[4*id +: 4] = 4'(steps);
    bus.req_valid[id]        = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      #1;
      if (bus.req_ready[id]) begin
        got = 1'b1;
        sbq.push_back('{id, exp, cyc + 1 + k});
        @(posedge clock);
        #1;
        bus.req_valid[id] = 1'b0;
      end else begin
        @(negedge clock);
      end
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: requester %0d got no ready, expected one", id);
      bus.req_valid[id] = 1'b0;
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && sbq.size() > 0; c++) @(negedge clock);
    if (sbq.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_acc;
    int  gid;
    bit  got;

    vt[0] = '{0, OP_UP,    0, 13,  1};  // 0 + 13 wraps 11->0 once
    vt[1] = '{1, OP_LOAD,  7,  0,  7};
    vt[2] = '{1, OP_DOWN,  0,  9, 10};  // 7 - 9 wraps 0->11
    vt[3] = '{0, OP_CLEAR, 0,  0,  0};
    vt[4] = '{1, OP_LOAD, 13,  0, 13};  // out-of-range value passes unchanged
    vt[5] = '{0, OP_UP,    0,  1,  0};  // 13 >= 11 wraps to 0
    vt[6] = '{1, OP_DOWN,  0,  1, 11};
    vt[7] = '{0, OP_UP,    0,  0, 11};  // zero steps holds
    vt[8] = '{1, OP_UP,    0,  4,  3};

    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_data  = '0;
    bus.req_steps = '0;

    // Reset held 3 cycles
    repeat (3) begin
      @(negedge clock);
      check("reset_ready", int'(bus.req_ready), 0);
      check("reset_rsp_valid", int'(bus.rsp_valid), 0);
      check("reset_ctr_clr", int'(ctr_clr), 1);
    end
    reset = 1'b0;
    #1;
    check("init_ctr_clr", int'(ctr_clr), 1);
    check("init_ready", int'(bus.req_ready), 0);
    @(negedge clock);
    check("idle_ctr_clr", int'(ctr_clr), 0);
    check("idle_count", int'(ctr_count), 0);
    check("idle_hold_load", int'(ctr_load), 1);

    // Table-driven commands
    for (int i = 0; i < 9; i++) begin
      issue(vt[i].id, vt[i].op, vt[i].data, vt[i].steps, vt[i].exp);
      drain();
    end

    // Both requesters continuously valid: grants alternate, count +1 each
    @(negedge clock);
    bus.req_op    = {OP_UP, OP_UP};
    bus.req_steps = {4'd1, 4'd1};
    bus.req_valid = 2'b11;
    n_acc = 0;
    for (int c = 0; c < 200 && n_acc < 4; c++) begin
      #1;
      if (|bus.req_ready) begin
        gid = bus.req_ready[1] ? 1 : 0;
        check("rr_grant", gid, n_acc % 2);
        check("ready_onehot", $countones(bus.req_ready), 1);
        sbq.push_back('{gid, 4 + n_acc, cyc + 2});
        n_acc++;
      end
      @(negedge clock);
    end
    bus.req_valid = 2'b00;
    check("rr_accepts", n_acc, 4);
    drain();

    // Reset in the middle of a DOWN 10
    @(negedge clock);
    bus.req_op[1:0]    = OP_DOWN;
    bus.req_steps[3:0] = 4'd10;
    bus.req_valid[0]   = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      #1;
      if (bus.req_ready[0]) begin
        got = 1'b1;
        @(posedge clock);
        #1;
        bus.req_valid[0] = 1'b0;
      end else begin
        @(negedge clock);
      end
    end
    check("abort_accepted", int'(got), 1);
    bus.req_valid[0] = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_ready", int'(bus.req_ready), 0);
    check("abort_rsp_valid", int'(bus.rsp_valid), 0);
    @(negedge clock);
    check("abort_ready2", int'(bus.req_ready), 0);
    reset = 1'b0;
    #1;
    check("abort_init_clr", int'(ctr_clr), 1);
    @(negedge clock);
    check("abort_count", int'(ctr_count), 0);
    repeat (15) @(negedge clock);

    // Idle hold after LOAD 5, then steps=0
    issue(1, OP_LOAD, 5, 0, 5);
    drain();
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      check("idle_hold_count", int'(ctr_count), 5);
    end
    issue(0, OP_UP, 0, 0, 5);
    drain();

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
